// File: rtl/lisnoc_dma_request_scheduler.sv
// Round-robin scheduler between the DMA request table and the request
// initiator. Offers one eligible slot at a time, tracks in-flight slots,
// caps concurrency and turns initiator completions into done pulses.
//
// Offer handshake: sched_req_valid stays high with sched_req_pos stable
// until the initiator accepts the offer with sched_req_ready=1 (the transfer
// happens on the clock edge where both are 1). The offer is also dropped
// if the table clears the offered slot's valid bit while ready is still 0.
module lisnoc_dma_request_scheduler #(
  parameter int table_entries          = 4,
  parameter int table_entries_ptrwidth = 2,
  parameter int max_outstanding        = 2,
  parameter int cnt_width              = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sched_en,
  input  logic [table_entries-1:0]          table_valid,
  output logic                              sched_req_valid,
  output logic [table_entries_ptrwidth-1:0] sched_req_pos,
  input  logic                              sched_req_ready,
  input  logic                              ctrl_done_en,
  input  logic [table_entries_ptrwidth-1:0] ctrl_done_pos,
  output logic                              table_done_en,
  output logic [table_entries_ptrwidth-1:0] table_done_pos,
  output logic [table_entries-1:0]          inflight,
  output logic [cnt_width-1:0]              outstanding,
  output logic                              done_err,
  output logic                              dbg_state
);

  typedef enum logic {
    st_arb   = 1'b0,
    st_offer = 1'b1
  } state_t;

  localparam logic [cnt_width-1:0] lp_max_cnt = cnt_width'(max_outstanding);

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [table_entries_ptrwidth-1:0] r_rr_ptr;
  logic [table_entries_ptrwidth-1:0] r_pos;
  logic [table_entries-1:0]          r_inflight;
  logic [cnt_width-1:0]              r_outstanding;
  logic                              r_done_en;
  logic [table_entries_ptrwidth-1:0] r_done_pos;
  logic                              r_done_err;

  logic [table_entries-1:0]          w_eligible;
  logic [table_entries_ptrwidth-1:0] w_pick;
  logic [table_entries_ptrwidth-1:0] w_idx;
  logic                              w_found;
  logic                              w_offer;
  logic                              w_hs;
  logic                              w_withdraw;
  logic                              w_done_ok;
  logic                              w_done_bad;
  logic [table_entries-1:0]          w_set_mask;
  logic [table_entries-1:0]          w_clr_mask;

  assign w_eligible = table_valid & ~r_inflight;
  assign w_hs       = (r_state == st_offer) && sched_req_ready;
  assign w_withdraw = (r_state == st_offer) && !sched_req_ready && !table_valid[r_pos];
  assign w_offer    = (r_state == st_arb) && sched_en && w_found && (r_outstanding < lp_max_cnt);
  // Completions are judged against the inflight vector before this edge.
  assign w_done_ok  = ctrl_done_en && r_inflight[ctrl_done_pos];
  assign w_done_bad = ctrl_done_en && !r_inflight[ctrl_done_pos];
  assign w_set_mask = w_hs ? (table_entries'(1) << r_pos) : '0;
  assign w_clr_mask = w_done_ok ? (table_entries'(1) << ctrl_done_pos) : '0;

  // Round-robin search starting at r_rr_ptr; pointer arithmetic wraps
  // naturally because table_entries is a power of two.
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < table_entries; i++) begin
      w_idx = r_rr_ptr + table_entries_ptrwidth'(i);
      if (!w_found && w_eligible[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= st_arb;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state: ARB launches an offer, OFFER waits for accept/withdraw.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      st_arb:   if (w_offer) w_state_nxt = st_offer;
      st_offer: if (w_hs || w_withdraw) w_state_nxt = st_arb;
      default:  w_state_nxt = st_arb;
    endcase
  end

  // Offer index, round-robin pointer, in-flight tracking and done pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr      <= '0;
      r_pos         <= '0;
      r_inflight    <= '0;
      r_outstanding <= '0;
      r_done_en     <= 1'b0;
      r_done_pos    <= '0;
      r_done_err    <= 1'b0;
    end else begin
      if (w_offer) r_pos <= w_pick;
      if (w_hs) r_rr_ptr <= r_pos + 1'b1;
      r_inflight <= (r_inflight & ~w_clr_mask) | w_set_mask;
      if (w_hs && !w_done_ok)      r_outstanding <= r_outstanding + 1'b1;
      else if (!w_hs && w_done_ok) r_outstanding <= r_outstanding - 1'b1;
      r_done_en  <= w_done_ok;
      if (w_done_ok) r_done_pos <= ctrl_done_pos;
      r_done_err <= w_done_bad;
    end
  end

  assign sched_req_valid = (r_state == st_offer);
  assign sched_req_pos   = r_pos;
  assign table_done_en   = r_done_en;
  assign table_done_pos  = r_done_pos;
  assign inflight        = r_inflight;
  assign outstanding     = r_outstanding;
  assign done_err        = r_done_err;
  assign dbg_state       = r_state;

  // The counter must stay within 0..max_outstanding.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    r_outstanding <= lp_max_cnt);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_done_ok && !w_hs && r_outstanding == '0));

endmodule
